// File: rtl/tmr_fault_injector.sv
// Fault-injecting driver for a 3-lane majority voter.
// Registers one data word and replicates it onto lanes a/b/c. A small campaign
// FSM can corrupt one chosen lane for a bounded number of valid beats, starting
// after a programmable number of clean beats.
module tmr_fault_injector #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
  input  logic             inj_start_i,
  input  logic [1:0]       inj_lane_i,
  input  logic [1:0]       inj_mode_i,
  input  logic [CNT_W-1:0] inj_delay_i,
  input  logic [CNT_W-1:0] inj_len_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o,
  output logic             valid_o,
  output logic             inj_busy_o,
  output logic             inj_active_o,
  output logic             inj_done_o,
  output logic             inj_err_o,
  output logic [CNT_W-1:0] inj_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_d;
  logic               corrupt;
  logic [WIDTH-1:0]   bad_data;
  logic [WIDTH-1:0]   a_d, b_d, c_d;

  // Campaign FSM: next state, latched configuration and beat counters.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    mode_d  = mode_q;
    dly_d   = dly_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    corrupt = (state_q == INJECT) && valid_i;
    case (state_q)
      IDLE: begin
        if (inj_start_i) begin
          if (inj_lane_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            lane_d = inj_lane_i;
            mode_d = inj_mode_i;
            dly_d  = inj_delay_i;
            len_d  = inj_len_i;
            cnt_d  = '0;
            if (inj_delay_i != '0)    state_d = ARM;
            else if (inj_len_i != '0) state_d = INJECT;
            else                      state_d = DONE;
          end
        end
      end
      ARM: begin
        // The beat that brings the delay to zero is still passed clean.
        if (valid_i) begin
          dly_d = dly_q - CNT_W'(1);
          if (dly_q == CNT_W'(1)) begin
            state_d = (len_q != '0) ? INJECT : DONE;
          end
        end
      end
      INJECT: begin
        if (valid_i) begin
          len_d = len_q - CNT_W'(1);
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (len_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Corrupted value for the selected lane and the per-lane next data.
  always_comb begin
    case (mode_q)
      2'd0:    bad_data = ~d_i;
      2'd1:    bad_data = '0;
      2'd2:    bad_data = '1;
      default: bad_data = d_i ^ WIDTH'(1);
    endcase
    a_d = (corrupt && lane_q == 2'd0) ? bad_data : d_i;
    b_d = (corrupt && lane_q == 2'd1) ? bad_data : d_i;
    c_d = (corrupt && lane_q == 2'd2) ? bad_data : d_i;
  end

  // FSM state and campaign configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      mode_q    <= '0;
      dly_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      inj_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      mode_q    <= mode_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      inj_err_o <= err_d;
    end
  end

  // Lane output registers: load on valid beats, hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_o          <= '0;
      b_o          <= '0;
      c_o          <= '0;
      valid_o      <= 1'b0;
      inj_active_o <= 1'b0;
    end else begin
      valid_o      <= valid_i;
      inj_active_o <= corrupt;
      if (valid_i) begin
        a_o <= a_d;
        b_o <= b_d;
        c_o <= c_d;
      end
    end
  end

  assign inj_busy_o = (state_q != IDLE);
  assign inj_done_o = (state_q == DONE);
  assign inj_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Scoreboard bench for tmr_fault_injector (WIDTH=3).
module tb_tmr_fault_injector;

  localparam int unsigned W = 3;
  localparam int unsigned C = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [W-1:0] d_i;
  logic         valid_i;
  logic         inj_start_i;
  logic [1:0]   inj_lane_i;
  logic [1:0]   inj_mode_i;
  logic [C-1:0] inj_delay_i;
  logic [C-1:0] inj_len_i;
  logic [W-1:0] a_o, b_o, c_o;
  logic         valid_o, inj_busy_o, inj_active_o, inj_done_o, inj_err_o;
  logic [C-1:0] inj_cnt_o;

  tmr_fault_injector #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(d_i), .valid_i(valid_i),
    .inj_start_i(inj_start_i), .inj_lane_i(inj_lane_i), .inj_mode_i(inj_mode_i),
    .inj_delay_i(inj_delay_i), .inj_len_i(inj_len_i),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .valid_o(valid_o),
    .inj_busy_o(inj_busy_o), .inj_active_o(inj_active_o), .inj_done_o(inj_done_o),
    .inj_err_o(inj_err_o), .inj_cnt_o(inj_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic         act;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bad_of(input int mode, input logic [W-1:0] d);
    case (mode)
      0:       return ~d;
      1:       return 3'b000;
      2:       return 3'b111;
      default: return d ^ 3'b001;
    endcase
  endfunction

  // Push one expectation: lane = -1 means all three lanes clean.
  task automatic push(input logic [W-1:0] d, input int lane, input int mode);
    exp_t e;
    e.a = d; e.b = d; e.c = d; e.d = d; e.act = 1'b0;
    if (lane >= 0) begin
      e.act = 1'b1;
      if (lane == 0) e.a = bad_of(mode, d);
      if (lane == 1) e.b = bad_of(mode, d);
      if (lane == 2) e.c = bad_of(mode, d);
    end
    sb.push_back(e);
  endtask

  task automatic beat(input logic [W-1:0] d, input int lane, input int mode);
    @(negedge clk_i);
    inj_start_i = 1'b0;
    d_i = d;
    valid_i = 1'b1;
    push(d, lane, mode);
    @(posedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      inj_start_i = 1'b0;
      valid_i = 1'b0;
      @(posedge clk_i);
    end
  endtask

  // Present a start request; optionally with a (clean) data beat in the same cycle.
  task automatic start(input int lane, input int mode, input int dly, input int len,
                       input logic with_beat, input logic [W-1:0] d);
    @(negedge clk_i);
    inj_start_i = 1'b1;
    inj_lane_i  = 2'(lane);
    inj_mode_i  = 2'(mode);
    inj_delay_i = C'(dly);
    inj_len_i   = C'(len);
    valid_i     = with_beat;
    d_i         = d;
    if (with_beat) push(d, -1, 0);
    @(posedge clk_i);
  endtask

  // Output monitor: compares every valid output beat against the scoreboard.
  always @(posedge clk_i) begin
    #1;
    if (rst_ni) begin
      if (inj_done_o) done_cnt++;
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic [W-1:0] maj;
          e = sb.pop_front();
          maj = (a_o & b_o) | (a_o & c_o) | (b_o & c_o);
          check("lane_a", 32'(a_o), 32'(e.a));
          check("lane_b", 32'(b_o), 32'(e.b));
          check("lane_c", 32'(c_o), 32'(e.c));
          check("active", 32'(inj_active_o), 32'(e.act));
          check("voter", 32'(maj), 32'(e.d));
        end
      end else begin
        check("active_idle", 32'(inj_active_o), 32'd0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst_ni = 1'b0; d_i = '0; valid_i = 1'b0; inj_start_i = 1'b0;
    inj_lane_i = '0; inj_mode_i = '0; inj_delay_i = '0; inj_len_i = '0;
    #2;
    check("rst_lanes", 32'({a_o, b_o, c_o}), 32'd0);
    check("rst_status", 32'({valid_o, inj_busy_o, inj_active_o, inj_done_o, inj_err_o}), 32'd0);
    check("rst_cnt", 32'(inj_cnt_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // 1: plain replication
    for (int i = 0; i < 8; i++) beat(W'(i), -1, 0);
    idle(1);
    check("t1_busy", 32'(inj_busy_o), 32'd0);

    // 2: lane b invert, delay 2, len 3; start cycle carries its own clean beat
    d0 = done_cnt;
    start(1, 0, 2, 3, 1'b1, 3'd5);
    beat(3'd5, -1, 0);
    beat(3'd5, -1, 0);
    beat(3'd5, 1, 0);
    beat(3'd5, 1, 0);
    beat(3'd5, 1, 0);
    #1;
    check("t2_done_after_5th", 32'(inj_done_o), 32'd1);
    beat(3'd5, -1, 0);
    #1;
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);
    check("t2_cnt", 32'(inj_cnt_o), 32'd3);
    check("t2_busy_end", 32'(inj_busy_o), 32'd0);

    // 3: zero delay and zero length
    d0 = done_cnt;
    start(2, 2, 0, 0, 1'b0, 3'd0);
    #1;
    check("t3_done", 32'(inj_done_o), 32'd1);
    check("t3_cnt_cleared", 32'(inj_cnt_o), 32'd0);
    beat(3'd6, -1, 0);
    beat(3'd1, -1, 0);
    #1;
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // 4: illegal lane, then a start ignored mid-campaign
    start(3, 0, 0, 2, 1'b0, 3'd0);
    #1;
    check("t4_err", 32'(inj_err_o), 32'd1);
    check("t4_busy", 32'(inj_busy_o), 32'd0);
    idle(1);
    #1;
    check("t4_err_pulse", 32'(inj_err_o), 32'd0);
    start(0, 0, 1, 1, 1'b0, 3'd0);
    start(1, 2, 0, 5, 1'b0, 3'd0);
    #1;
    check("t4_no_err_mid", 32'(inj_err_o), 32'd0);
    check("t4_busy_mid", 32'(inj_busy_o), 32'd1);
    beat(3'd3, -1, 0);
    beat(3'd3, 0, 0);
    beat(3'd6, -1, 0);
    #1;
    check("t4_cnt", 32'(inj_cnt_o), 32'd1);

    // 5: reset aborts a stuck-0 campaign on lane a
    d0 = done_cnt;
    start(0, 1, 0, 4, 1'b0, 3'd0);
    beat(3'd7, 0, 1);
    beat(3'd6, 0, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("t5_lanes", 32'({a_o, b_o, c_o}), 32'd0);
    check("t5_status", 32'({valid_o, inj_busy_o, inj_active_o, inj_done_o, inj_err_o}), 32'd0);
    check("t5_cnt", 32'(inj_cnt_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    beat(3'd3, -1, 0);
    beat(3'd4, -1, 0);
    idle(2);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // 6: gaps between corrupted beats (lane b, LSB flip)
    d0 = done_cnt;
    start(1, 3, 0, 2, 1'b0, 3'd0);
    beat(3'd4, 1, 3);
    idle(10);
    #1;
    check("t6_busy_gap", 32'(inj_busy_o), 32'd1);
    check("t6_cnt_gap", 32'(inj_cnt_o), 32'd1);
    beat(3'd6, 1, 3);
    beat(3'd1, -1, 0);
    idle(2);
    check("t6_cnt", 32'(inj_cnt_o), 32'd2);
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
